// File: rtl/riscv_data_mem_resp_if.sv
// riscv_data_mem_resp_if: OBI-style LSU data bus between a load/store unit and its data memory.
interface riscv_data_mem_resp_if;
    logic        data_req_i;
    logic        data_gnt_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface

// File: rtl/riscv_data_mem_resp.sv
// riscv_data_mem_resp: fixed-latency data memory answering LSU requests in grant order,
// with byte-enabled stores and an out-of-range error response.
module riscv_data_mem_resp #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_i,
    riscv_data_mem_resp_if.slave   bus
);
    if (LATENCY < 1 || LATENCY > 4) begin : g_latency_check
        $error("riscv_data_mem_resp: LATENCY must be in 1..4");
    end

    logic [31:0]               mem [2**ADDR_WIDTH];
    logic                      gnt;
    logic                      err;
    logic [ADDR_WIDTH-1:0]     idx;
    logic [LATENCY-1:0]        v;
    logic [LATENCY-1:0]        e;
    logic [LATENCY-1:0][31:0]  d;

    assign gnt = bus.data_req_i & ~stall_i & rst_n;
    assign err = (bus.data_addr_i >> (ADDR_WIDTH + 2)) != 32'd0;
    assign idx = bus.data_addr_i[ADDR_WIDTH+1:2];

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = v[LATENCY-1];
    assign bus.data_err_o    = e[LATENCY-1];
    assign bus.data_rdata_o  = d[LATENCY-1];

    // Array contents survive reset; only the response pipeline is cleared.
    always_ff @(posedge clk) begin
        if (gnt && bus.data_we_i && !err)
            for (int i = 0; i < 4; i++)
                if (bus.data_be_i[i]) mem[idx][8*i +: 8] <= bus.data_wdata_i[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            e <= '0;
            d <= '0;
        end else begin
            v[0] <= gnt;
            e[0] <= gnt && err;
            d[0] <= (gnt && !bus.data_we_i && !err) ? mem[idx] : 32'd0;
            for (int i = 1; i < LATENCY; i++) begin
                v[i] <= v[i-1];
                e[i] <= e[i-1];
                d[i] <= d[i-1];
            end
        end
    end
endmodule

// File: tb/tb_riscv_data_mem_resp.sv
// tb_riscv_data_mem_resp: drives a LATENCY=1 and a LATENCY=3 instance with identical traffic and
// checks both against a word-array / due-cycle response queue model.
module tb_riscv_data_mem_resp;
    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    localparam int AW        = 10;
    localparam int MEM_BYTES = 4 * (1 << AW);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] ref_mem [1 << AW];
    rsp_t        q1[$];
    rsp_t        q3[$];

    riscv_data_mem_resp_if bus1();
    riscv_data_mem_resp_if bus3();

    riscv_data_mem_resp #(.ADDR_WIDTH(AW), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .bus(bus1)
    );
    riscv_data_mem_resp #(.ADDR_WIDTH(AW), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .bus(bus3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // One bus cycle: drive, check outputs mid-cycle, then let the model see the grant edge.
    task automatic step(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input logic stl);
        rsp_t        r;
        logic        bad;
        logic [31:0] m;
        logic [31:0] rd;
        bus1.data_req_i = req;  bus3.data_req_i = req;
        bus1.data_we_i = we;    bus3.data_we_i = we;
        bus1.data_addr_i = addr; bus3.data_addr_i = addr;
        bus1.data_be_i = be;    bus3.data_be_i = be;
        bus1.data_wdata_i = wdata; bus3.data_wdata_i = wdata;
        stall = stl;
        if (!rst_n) begin
            q1.delete();
            q3.delete();
        end
        @(negedge clk);
        chk("gnt_l1", {31'd0, bus1.data_gnt_o}, {31'd0, req & ~stl & rst_n});
        chk("gnt_l3", {31'd0, bus3.data_gnt_o}, {31'd0, req & ~stl & rst_n});
        r = '{due: 0, err: 1'b0, data: 32'd0};
        if (q1.size() > 0 && q1[0].due == cyc) begin
            r = q1.pop_front();
            chk("rvalid_l1", {31'd0, bus1.data_rvalid_o}, 32'd1);
        end else chk("rvalid_l1", {31'd0, bus1.data_rvalid_o}, 32'd0);
        chk("err_l1", {31'd0, bus1.data_err_o}, {31'd0, r.err});
        chk("rdata_l1", bus1.data_rdata_o, r.data);
        r = '{due: 0, err: 1'b0, data: 32'd0};
        if (q3.size() > 0 && q3[0].due == cyc) begin
            r = q3.pop_front();
            chk("rvalid_l3", {31'd0, bus3.data_rvalid_o}, 32'd1);
        end else chk("rvalid_l3", {31'd0, bus3.data_rvalid_o}, 32'd0);
        chk("err_l3", {31'd0, bus3.data_err_o}, {31'd0, r.err});
        chk("rdata_l3", bus3.data_rdata_o, r.data);
        if (req && !stl && rst_n) begin
            bad = addr >= MEM_BYTES;
            m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            if (we && !bad) ref_mem[addr >> 2] = (ref_mem[addr >> 2] & ~m) | (wdata & m);
            rd = (we || bad) ? 32'd0 : ref_mem[addr >> 2];
            q1.push_back('{due: cyc + 1, err: bad, data: rd});
            q3.push_back('{due: cyc + 3, err: bad, data: rd});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        // reset: requests are not granted and outputs stay quiet
        step(1'b1, 1'b0, 32'h10, 4'hF, 32'd0, 1'b0);
        step(1'b1, 1'b1, 32'h10, 4'hF, 32'h55, 1'b0);
        rst_n = 1'b1;
        idle(1);
        // full-word store then immediate read-after-write
        step(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        step(1'b1, 1'b0, 32'h10, 4'h0, 32'd0, 1'b0);
        idle(3);
        // partial byte enables and an empty-mask store
        step(1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0);
        step(1'b1, 1'b1, 32'h20, 4'b0010, 32'hAABBCCDD, 1'b0);
        step(1'b1, 1'b0, 32'h22, 4'b0001, 32'd0, 1'b0);
        step(1'b1, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 1'b0);
        step(1'b1, 1'b0, 32'h20, 4'hF, 32'd0, 1'b0);
        idle(3);
        // range boundaries: last valid word, first and last invalid addresses
        step(1'b1, 1'b1, 32'h0, 4'hF, 32'h0BADF00D, 1'b0);
        step(1'b1, 1'b1, 32'h1000, 4'hF, 32'h12345678, 1'b0);
        step(1'b1, 1'b0, 32'h1000, 4'hF, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'hFFFFFFFC, 4'hF, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 4'hF, 32'd0, 1'b0);
        step(1'b1, 1'b1, 32'hFFC, 4'hF, 32'h87654321, 1'b0);
        step(1'b1, 1'b0, 32'hFFC, 4'hF, 32'd0, 1'b0);
        idle(3);
        // back-to-back loads of 1,2,3,4
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h40 + 4 * i, 4'hF, i + 1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h40 + 4 * i, 4'hF, 32'd0, 1'b0);
        idle(4);
        // stall holds off a pending request, release grants in the same cycle
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h44, 4'hF, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'h44, 4'hF, 32'd0, 1'b0);
        idle(4);
        // reset while two loads are in flight drops them; the earlier store persists
        step(1'b1, 1'b1, 32'h80, 4'hF, 32'hCAFEF00D, 1'b0);
        step(1'b1, 1'b0, 32'h40, 4'hF, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'h44, 4'hF, 32'd0, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 32'h48, 4'hF, 32'd0, 1'b0);
        rst_n = 1'b1;
        idle(4);
        step(1'b1, 1'b0, 32'h80, 4'hF, 32'd0, 1'b0);
        idle(4);
        // random traffic over a prefilled window
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 4 * i, 4'hF, $urandom, 1'b0);
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h1000) : $urandom_range(0, 127);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
                 4'($urandom), $urandom, $urandom_range(0, 4) == 0);
        end
        idle(5);
        chk("drain_l1", q1.size(), 32'd0);
        chk("drain_l3", q3.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/riscv_data_mem_resp.md
# riscv_data_mem_resp

Synthesisable data-memory responder for the core's load/store unit: the memory-side end of the LSU data bus. Accepts one request per cycle on an OBI-style req/gnt channel and performs byte-enabled writes into an internal word array. Returns read data or an error flag on rvalid a fixed, parameterised number of cycles after grant, strictly in order. Used as the data memory in core-level simulation and as the LSU bus peer in the verification environment.

## Interface
- ADDR_WIDTH, 10, word-address bits; array holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 1, cycles from grant to rvalid; legal range 1..4, any other value is an elaboration error.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_req_i  in  1  request valid from LSU.
- data_gnt_o  out  1  request accepted this cycle.
- data_addr_i  in  32  byte address; bits [1:0] ignored.
- data_we_i  in  1  LOAD=0, STORE=1 (package we_e encoding).
- data_be_i  in  4  byte enables; bit n selects bits [8n+7:8n].
- data_wdata_i  in  32  store data, already lane-aligned by LSU.
- stall_i  in  1  bench/arbiter back-pressure; forces data_gnt_o=0.
- data_rvalid_o  out  1  response valid; one per granted request.
- data_rdata_o  out  32  read data; 0 for stores and errors.
- data_err_o  out  1  access error, valid with data_rvalid_o.

## Operation
- Grant: data_gnt_o = data_req_i & ~stall_i & rst_n, combinational. No outstanding limit; the pipeline is fixed-latency, so no response back-pressure exists.
- Range check: error when data_addr_i[31:ADDR_WIDTH+2] != 0. Index = data_addr_i[ADDR_WIDTH+1:2].
- Store (granted, we=1, no error): each byte lane with be=1 written at the grant clock edge. Lanes with be=0 unchanged. be=0000 is a legal no-op write with a normal response.
- Load (granted, we=0, no error): full 32-bit word read at grant, captured into stage 1. be is ignored for reads; the LSU performs lane selection and ZERO_EXT/SIGN_EXT.
- Errored access: no array write; response carries err=1, rdata=0.
- Response pipeline: LATENCY stages of {valid, err, rdata}, shifting every cycle unconditionally. The last stage drives the outputs.
- Ordering: responses leave in grant order. One response per cycle maximum.
- Read-after-write: a load granted the cycle after a store to the same word returns the new data. Same-cycle conflicts are impossible (one request per cycle).
- Memory contents are not reset. Contents are undefined until written; the bench writes before reading.

## Timing
- Reset (rst_n low, async): all pipeline valid bits clear; data_rvalid_o=0, data_rdata_o=0, data_err_o=0. data_gnt_o=0 while rst_n low.
- Reset asserted mid-operation: in-flight responses are dropped. Stores already granted remain in the array.
- Latency: a request granted at edge N produces data_rvalid_o=1 in the cycle after edge N+LATENCY-1. With LATENCY=1 this is the cycle immediately after grant.
- Back-to-back grants give back-to-back rvalid pulses, rdata changing every cycle.
- data_rvalid_o is a single-cycle pulse per response. rdata/err hold 0 when rvalid=0.
- stall_i: combinational effect on gnt the same cycle. The LSU holds req/addr/we/be/wdata stable until granted.
- Ungranted requests have no side effects.
- Pipeline drains normally while stall_i=1.

## Test plan
- LATENCY=1: store 0xDEADBEEF be=1111 to 0x10, then load 0x10 → rvalid one cycle after each grant; load rdata=0xDEADBEEF, err=0.
- Byte enables: preload 0x11223344 at 0x20, store wdata 0xAABBCCDD be=0010, load → rdata=0x1122CC44.
- Out of range (ADDR_WIDTH=10): store then load at 0x0000_1000 → both err=1, rdata=0. Load of 0x0 afterwards is unchanged.
- LATENCY=3, four back-to-back loads of words holding 1,2,3,4 → rvalid high four consecutive cycles starting 3 cycles after first grant; rdata 1,2,3,4 in order.
- stall_i=1 for 5 cycles with req=1 → gnt=0 throughout, no rvalid. Release → gnt same cycle, response after LATENCY.
- rst_n low one cycle after granting two loads (LATENCY=3) → rvalid never asserts for them, outputs 0. A store granted before reset is visible to a post-reset load.
